// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_if
//  Purpose  : Writeback request/grant bundle between the FU result registers
//             (master side) and the CDB arbiter (slave side).
//  Revision : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int FU_SIZE = 20,
    parameter int NUM_CDB = 2,
    parameter int IDX_W   = 5
);
    logic [FU_SIZE-1:0]       fu_result_valid;
    logic                     cdb_stall;
    logic [FU_SIZE-1:0]       fu_grant;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*IDX_W-1:0] cdb_fu_num;
    logic [NUM_CDB*4-1:0]     cdb_cat;

    modport master (
        output fu_result_valid,
        output cdb_stall,
        input  fu_grant,
        input  cdb_valid,
        input  cdb_fu_num,
        input  cdb_cat
    );

    modport slave (
        input  fu_result_valid,
        input  cdb_stall,
        output fu_grant,
        output cdb_valid,
        output cdb_fu_num,
        output cdb_cat
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Picks up to NUM_CDB completed FU results per cycle for the
//             common data buses. Fixed category priority BEQ > MULT > LS > ALU,
//             round-robin inside each category, starved categories promoted.
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_ALU      = 8,
    parameter int NUM_LS       = 4,
    parameter int NUM_MULT     = 4,
    parameter int NUM_BEQ      = 4,
    parameter int NUM_CDB      = 2,
    parameter int STARVE_LIMIT = 7
) (
    input  wire logic    clock,
    input  wire logic    reset,
    cdb_arbiter_if.slave bus
);
    localparam int FU_SIZE = NUM_ALU + NUM_LS + NUM_MULT + NUM_BEQ;
    localparam int IDX_W   = $clog2(FU_SIZE);

    // Category index: 0 ALU, 1 LS, 2 MULT, 3 BEQ (matches the one-hot cdb_cat bits)
    localparam int c_CAT_N    [4] = '{NUM_ALU, NUM_LS, NUM_MULT, NUM_BEQ};
    localparam int c_CAT_BASE [4] = '{0, NUM_ALU, NUM_ALU + NUM_LS, NUM_ALU + NUM_LS + NUM_MULT};
    localparam int c_MAX_AL   = (NUM_ALU > NUM_LS) ? NUM_ALU : NUM_LS;
    localparam int c_MAX_MB   = (NUM_MULT > NUM_BEQ) ? NUM_MULT : NUM_BEQ;
    localparam int c_MAX_N    = (c_MAX_AL > c_MAX_MB) ? c_MAX_AL : c_MAX_MB;
    // One shared pointer width; each pointer only ever holds values below its own category size
    localparam int c_PTR_W    = (c_MAX_N > 1) ? $clog2(c_MAX_N) : 1;
    localparam int c_CNT_W    = $clog2(STARVE_LIMIT + 1);

    logic [c_PTR_W-1:0] r_rr_ptr     [4];
    logic [c_CNT_W-1:0] r_starve_cnt [4];

    logic [3:0]         w_starved;
    logic [3:0]         w_cat_req;
    logic [3:0]         w_cat_hit;
    logic [1:0]         w_order    [4];
    logic [c_PTR_W-1:0] w_last_loc [4];
    logic [c_PTR_W-1:0] w_next_ptr [4];
    logic [FU_SIZE-1:0] w_grant;
    logic [NUM_CDB-1:0] w_slot_valid;
    logic [IDX_W-1:0]   w_slot_fu  [NUM_CDB];
    logic [3:0]         w_slot_cat [NUM_CDB];

    for (genvar g = 0; g < 4; g++) begin : g_cat
        assign w_cat_req[g]  = |bus.fu_result_valid[c_CAT_BASE[g] +: c_CAT_N[g]];
        assign w_starved[g]  = (r_starve_cnt[g] == c_CNT_W'(STARVE_LIMIT));
        // Wrap exactly at the category size so non-power-of-two counts stay in range
        assign w_next_ptr[g] = (int'(w_last_loc[g]) == c_CAT_N[g] - 1) ? '0
                                                                        : w_last_loc[g] + c_PTR_W'(1);
    end

    // Effective category order: starved categories first, each group in BEQ..ALU base order
    always_comb begin
        logic [2:0] w_fill;
        w_fill = '0;
        for (int i = 0; i < 4; i++) begin
            w_order[i] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            for (int b = 3; b >= 0; b--) begin
                if (w_starved[b] == (p == 0)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_fill == 3'(i)) begin
                            w_order[i] = 2'(b);
                        end
                    end
                    w_fill = w_fill + 3'd1;
                end
            end
        end
    end

    // Walk categories in effective order, each from its pointer with wrap, filling slots in turn
    always_comb begin
        logic [2:0]       w_slot;
        int               w_loc;
        logic [IDX_W-1:0] w_fu;
        w_slot       = '0;
        w_loc        = 0;
        w_fu         = '0;
        w_grant      = '0;
        w_slot_valid = '0;
        w_cat_hit    = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            w_slot_fu[k]  = '0;
            w_slot_cat[k] = '0;
        end
        for (int c = 0; c < 4; c++) begin
            w_last_loc[c] = '0;
        end
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 4; c++) begin
                if (w_order[o] == 2'(c)) begin
                    for (int j = 0; j < c_MAX_N; j++) begin
                        if (j < c_CAT_N[c]) begin
                            w_loc = int'(r_rr_ptr[c]) + j;
                            if (w_loc >= c_CAT_N[c]) begin
                                w_loc = w_loc - c_CAT_N[c];
                            end
                            w_fu = IDX_W'(c_CAT_BASE[c] + w_loc);
                            if ((w_slot < 3'(NUM_CDB)) && bus.fu_result_valid[w_fu]) begin
                                for (int k = 0; k < NUM_CDB; k++) begin
                                    if (w_slot == 3'(k)) begin
                                        w_slot_valid[k] = 1'b1;
                                        w_slot_fu[k]    = w_fu;
                                        w_slot_cat[k]   = 4'(1 << c);
                                    end
                                end
                                w_grant[w_fu] = 1'b1;
                                w_cat_hit[c]  = 1'b1;
                                // Later slots overwrite, leaving the last local index granted
                                w_last_loc[c] = c_PTR_W'(w_loc);
                                w_slot        = w_slot + 3'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Drive the bus; reset and stall both blank every output
    always_comb begin
        bus.fu_grant   = '0;
        bus.cdb_valid  = '0;
        bus.cdb_fu_num = '0;
        bus.cdb_cat    = '0;
        if (!reset && !bus.cdb_stall) begin
            bus.fu_grant  = w_grant;
            bus.cdb_valid = w_slot_valid;
            for (int k = 0; k < NUM_CDB; k++) begin
                bus.cdb_fu_num[k*IDX_W +: IDX_W] = w_slot_fu[k];
                bus.cdb_cat[k*4 +: 4]            = w_slot_cat[k];
            end
        end
    end

    // Fairness state: pointers advance past the last winner, counters track ungranted requests
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                r_rr_ptr[c]     <= '0;
                r_starve_cnt[c] <= '0;
            end
        end else if (!bus.cdb_stall) begin
            for (int c = 0; c < 4; c++) begin
                if (w_cat_hit[c]) begin
                    r_rr_ptr[c] <= w_next_ptr[c];
                end
                if (w_cat_hit[c] || !w_cat_req[c]) begin
                    r_starve_cnt[c] <= '0;
                end else if (!w_starved[c]) begin
                    r_starve_cnt[c] <= r_starve_cnt[c] + c_CNT_W'(1);
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter. Instance A uses the default
//             category sizes (2 slots, limit 3); instance C uses 7/3/2/1 FUs,
//             one slot and limit 2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a;
    logic rst_c;

    cdb_arbiter_if #(.FU_SIZE(20), .NUM_CDB(2), .IDX_W(5)) ifa ();
    cdb_arbiter_if #(.FU_SIZE(13), .NUM_CDB(1), .IDX_W(4)) ifc ();

    cdb_arbiter #(.STARVE_LIMIT(3)) u_dut_a (
        .clock (clock),
        .reset (rst_a),
        .bus   (ifa)
    );

    cdb_arbiter #(
        .NUM_ALU(7), .NUM_LS(3), .NUM_MULT(2), .NUM_BEQ(1),
        .NUM_CDB(1), .STARVE_LIMIT(2)
    ) u_dut_c (
        .clock (clock),
        .reset (rst_c),
        .bus   (ifc)
    );

    // Reference model configuration: index 0 = instance A, 1 = instance C
    int cfg_n    [2][4] = '{'{8, 4, 4, 4}, '{7, 3, 2, 1}};
    int cfg_cdb  [2]    = '{2, 1};
    int cfg_lim  [2]    = '{3, 2};
    int cfg_idxw [2]    = '{5, 4};

    int m_ptr   [2][4];
    int m_cnt   [2][4];
    int sel_fu  [2][4];
    int sel_cat [2][4];
    int nsel    [2];

    logic [31:0] in_req   [2];
    bit          in_stall [2];
    bit          in_rst   [2];

    logic [31:0] e_grant [2];
    logic [31:0] e_fu    [2];
    logic [3:0]  e_valid [2];
    logic [15:0] e_cat   [2];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int cat_base(input int m, input int c);
        int s;
        s = 0;
        for (int i = 0; i < c; i++) s += cfg_n[m][i];
        return s;
    endfunction

    // Build the candidate list from the rules and keep the first cfg_cdb entries
    task automatic model_select(input int m, input logic [31:0] req);
        int order[$];
        int c;
        int g;
        order = {};
        for (int p = 0; p < 2; p++)
            for (int cc = 3; cc >= 0; cc--)
                if ((m_cnt[m][cc] == cfg_lim[m]) == (p == 0)) order.push_back(cc);
        nsel[m] = 0;
        foreach (order[i]) begin
            c = order[i];
            for (int j = 0; j < cfg_n[m][c]; j++) begin
                g = cat_base(m, c) + (m_ptr[m][c] + j) % cfg_n[m][c];
                if (req[g] && nsel[m] < cfg_cdb[m]) begin
                    sel_fu[m][nsel[m]]  = g;
                    sel_cat[m][nsel[m]] = c;
                    nsel[m]++;
                end
            end
        end
    endtask

    task automatic model_expect(input int m);
        e_grant[m] = '0;
        e_valid[m] = '0;
        e_fu[m]    = '0;
        e_cat[m]   = '0;
        if (!in_rst[m] && !in_stall[m]) begin
            model_select(m, in_req[m]);
            for (int k = 0; k < nsel[m]; k++) begin
                e_grant[m][sel_fu[m][k]] = 1'b1;
                e_valid[m][k]            = 1'b1;
                e_fu[m]  = e_fu[m] | (32'(sel_fu[m][k]) << (k * cfg_idxw[m]));
                e_cat[m] = e_cat[m] | (16'(1 << sel_cat[m][k]) << (4 * k));
            end
        end
    endtask

    task automatic model_update(input int m);
        bit granted;
        bit reqany;
        int last;
        if (in_rst[m]) begin
            for (int c = 0; c < 4; c++) begin
                m_ptr[m][c] = 0;
                m_cnt[m][c] = 0;
            end
        end else if (!in_stall[m]) begin
            model_select(m, in_req[m]);
            for (int c = 0; c < 4; c++) begin
                granted = 1'b0;
                last    = 0;
                for (int k = 0; k < nsel[m]; k++)
                    if (sel_cat[m][k] == c) begin
                        granted = 1'b1;
                        last    = sel_fu[m][k] - cat_base(m, c);
                    end
                reqany = 1'b0;
                for (int j = 0; j < cfg_n[m][c]; j++)
                    if (in_req[m][cat_base(m, c) + j]) reqany = 1'b1;
                if (granted) m_ptr[m][c] = (last + 1) % cfg_n[m][c];
                if (granted || !reqany) m_cnt[m][c] = 0;
                else if (m_cnt[m][c] < cfg_lim[m]) m_cnt[m][c]++;
            end
        end
    endtask

    // Drive both instances just after a falling edge and settle the model expectations
    task automatic apply(input logic [31:0] ra, input bit sa, input bit xa,
                         input logic [31:0] rc, input bit sc, input bit xc);
        in_req[0] = ra; in_stall[0] = sa; in_rst[0] = xa;
        in_req[1] = rc; in_stall[1] = sc; in_rst[1] = xc;
        ifa.fu_result_valid = ra[19:0];
        ifa.cdb_stall       = sa;
        rst_a               = xa;
        ifc.fu_result_valid = rc[12:0];
        ifc.cdb_stall       = sc;
        rst_c               = xc;
        #1;
        model_expect(0);
        model_expect(1);
    endtask

    task automatic next_cycle();
        model_update(0);
        model_update(1);
        @(negedge clock);
    endtask

    task automatic reset_both();
        apply(32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        next_cycle();
    endtask

    task automatic test_reset();
        apply(32'hFFFFF, 1'b0, 1'b1, 32'h1FFF, 1'b0, 1'b1);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== 40'h0) begin
            n_bad++;
            $display("FAIL reset_outputs_a: got valid=%b fu=%h cat=%h grant=%h, want all 0",
                     ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        n_cmp++;
        if ({ifc.cdb_valid, ifc.cdb_fu_num, ifc.cdb_cat, ifc.fu_grant} !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_outputs_c: got valid=%b fu=%h cat=%h grant=%h, want all 0",
                     ifc.cdb_valid, ifc.cdb_fu_num, ifc.cdb_cat, ifc.fu_grant);
        end
        next_cycle();
        // First post-reset cycle: base order, BEQ pointer 0 -> FUs 16 and 17
        apply(32'hFFFFF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== {2'b11, 10'd560, 8'h88, 20'h30000}) begin
            n_bad++;
            $display("FAIL reset_first_grant: got valid=%b fu=%h cat=%h grant=%h, want valid=11 fu=230 cat=88 grant=30000",
                     ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        next_cycle();
    endtask

    task automatic test_single();
        reset_both();
        apply(32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== {2'b01, 10'd5, 8'h01, 20'h00020}) begin
            n_bad++;
            $display("FAIL single_req: got valid=%b fu=%h cat=%h grant=%h, want valid=01 fu=005 cat=01 grant=00020",
                     ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        next_cycle();
        // ALU pointer is now 6: ALU 7 ranks before ALU 2
        apply(32'h84, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== {2'b11, 10'd71, 8'h11, 20'h00084}) begin
            n_bad++;
            $display("FAIL single_ptr_follow: got valid=%b fu=%h cat=%h grant=%h, want valid=11 fu=047 cat=11 grant=00084",
                     ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        next_cycle();
    endtask

    task automatic test_cross();
        reset_both();
        apply(32'h20204, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== {2'b11, 10'd305, 8'h28, 20'h20200}) begin
            n_bad++;
            $display("FAIL cross_cat: got valid=%b fu=%h cat=%h grant=%h, want valid=11 fu=131 cat=28 grant=20200",
                     ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        next_cycle();
    endtask

    task automatic test_rotation();
        int rot_exp [5];
        rot_exp = '{1, 3, 6, 1, 3};
        reset_both();
        for (int i = 0; i < 5; i++) begin
            apply(32'h0, 1'b0, 1'b0, 32'h4A, 1'b0, 1'b0);
            n_cmp++;
            if ({ifc.cdb_valid, ifc.cdb_fu_num, ifc.cdb_cat, ifc.fu_grant} !==
                {1'b1, 4'(rot_exp[i]), 4'b0001, 13'(1 << rot_exp[i])}) begin
                n_bad++;
                $display("FAIL rotation[%0d]: got valid=%b fu=%0d grant=%h, want valid=1 fu=%0d",
                         i, ifc.cdb_valid, ifc.cdb_fu_num, ifc.fu_grant, rot_exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        logic [9:0]  xfu   [5];
        logic [7:0]  xcat  [5];
        logic [19:0] xgnt  [5];
        xfu  = '{10'd560, 10'd560, 10'd560, 10'd512, 10'd529};
        xcat = '{8'h88, 8'h88, 8'h88, 8'h81, 8'h88};
        xgnt = '{20'h30000, 20'h30000, 20'h30000, 20'h10001, 20'h30000};
        reset_both();
        for (int i = 0; i < 5; i++) begin
            apply(32'h30001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            n_cmp++;
            if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== {2'b11, xfu[i], xcat[i], xgnt[i]}) begin
                n_bad++;
                $display("FAIL starve[%0d]: got fu=%h cat=%h grant=%h, want fu=%h cat=%h grant=%h",
                         i, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant, xfu[i], xcat[i], xgnt[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        reset_both();
        for (int i = 0; i < 3; i++) begin
            apply(32'h3000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            n_cmp++;
            if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== 40'h0) begin
                n_bad++;
                $display("FAIL stall_blank[%0d]: got valid=%b fu=%h cat=%h grant=%h, want all 0",
                         i, ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
            end
            next_cycle();
        end
        apply(32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== {2'b11, 10'd428, 8'h44, 20'h03000}) begin
            n_bad++;
            $display("FAIL stall_release: got valid=%b fu=%h cat=%h grant=%h, want valid=11 fu=1ac cat=44 grant=03000",
                     ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        next_cycle();
        // Reach the threshold, stall across it, then expect promotion on release
        reset_both();
        for (int i = 0; i < 3; i++) begin
            apply(32'h30001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            next_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            apply(32'h30001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            next_cycle();
        end
        apply(32'h30001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== {2'b11, 10'd512, 8'h81, 20'h10001}) begin
            n_bad++;
            $display("FAIL stall_starve_promote: got fu=%h cat=%h grant=%h, want fu=200 cat=81 grant=10001",
                     ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        reset_both();
        apply(32'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_fu_num, ifa.fu_grant} !== {10'd32, 20'h00003}) begin
            n_bad++;
            $display("FAIL mid_rotate0: got fu=%h grant=%h, want fu=020 grant=00003", ifa.cdb_fu_num, ifa.fu_grant);
        end
        next_cycle();
        apply(32'hC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        apply(32'h22, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== 40'h0) begin
            n_bad++;
            $display("FAIL mid_reset_blank: got valid=%b fu=%h cat=%h grant=%h, want all 0",
                     ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        next_cycle();
        apply(32'h22, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !== {2'b11, 10'd161, 8'h11, 20'h00022}) begin
            n_bad++;
            $display("FAIL mid_reset_after: got valid=%b fu=%h cat=%h grant=%h, want valid=11 fu=0a1 cat=11 grant=00022",
                     ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant);
        end
        next_cycle();
    endtask

    // FUs hold results until granted; random arrivals, stalls and occasional resets
    task automatic test_random();
        logic [31:0] pend [2];
        int          size [2];
        bit          st   [2];
        bit          rs   [2];
        size[0] = 20; size[1] = 13;
        pend[0] = '0; pend[1] = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                for (int g = 0; g < size[m]; g++)
                    if (!pend[m][g] && $urandom_range(0, 99) < 35) pend[m][g] = 1'b1;
                st[m] = ($urandom_range(0, 7) == 0);
                rs[m] = ($urandom_range(0, 149) == 0);
            end
            apply(pend[0], st[0], rs[0], pend[1], st[1], rs[1]);
            n_cmp++;
            if ({ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant} !==
                {e_valid[0][1:0], e_fu[0][9:0], e_cat[0][7:0], e_grant[0][19:0]}) begin
                n_bad++;
                $display("FAIL rand_a cyc=%0d req=%h: got valid=%b fu=%h cat=%h grant=%h, want valid=%b fu=%h cat=%h grant=%h",
                         cyc, pend[0][19:0], ifa.cdb_valid, ifa.cdb_fu_num, ifa.cdb_cat, ifa.fu_grant,
                         e_valid[0][1:0], e_fu[0][9:0], e_cat[0][7:0], e_grant[0][19:0]);
            end
            n_cmp++;
            if ({ifc.cdb_valid, ifc.cdb_fu_num, ifc.cdb_cat, ifc.fu_grant} !==
                {e_valid[1][0], e_fu[1][3:0], e_cat[1][3:0], e_grant[1][12:0]}) begin
                n_bad++;
                $display("FAIL rand_c cyc=%0d req=%h: got valid=%b fu=%h cat=%h grant=%h, want valid=%b fu=%h cat=%h grant=%h",
                         cyc, pend[1][12:0], ifc.cdb_valid, ifc.cdb_fu_num, ifc.cdb_cat, ifc.fu_grant,
                         e_valid[1][0], e_fu[1][3:0], e_cat[1][3:0], e_grant[1][12:0]);
            end
            pend[0] = pend[0] & ~e_grant[0];
            pend[1] = pend[1] & ~e_grant[1];
            next_cycle();
        end
    endtask

    initial begin
        rst_a               = 1'b1;
        rst_c               = 1'b1;
        ifa.fu_result_valid = '0;
        ifa.cdb_stall       = 1'b0;
        ifc.fu_result_valid = '0;
        ifc.cdb_stall       = 1'b0;
        @(negedge clock);
        test_reset();
        test_single();
        test_cross();
        test_rotation();
        test_starvation();
        test_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
